// File: rtl/ps2_button_mapper.sv
// -----------------------------------------------------------------------------
// ps2_button_mapper
//
// Turns the hps_io ps2_key event bus into NUM_BTN held-button bits. Each
// button is matched against a run-time loadable table entry. Joystick bits
// are OR-merged in, and buttons selected by PULSE_MASK (coin/start) are held
// high for at least PULSE_CYCLES+1 cycles after any rising edge.
//
// Ports
//   clk_sys    in   1        system clock, rising edge
//   reset_n    in   1        asynchronous active-low reset
//   ps2_key    in   11       [10] toggle, [9] pressed, [8:0] code ([8] = E0)
//   joy        in   NUM_BTN  joystick bits, active high, aligned to buttons
//   cfg_wr     in   1        one-cycle table write strobe
//   cfg_idx    in   5        entry to write (>= NUM_BTN ignored)
//   cfg_entry  in   11       [10] valid, [9] ignore-extended, [8:0] code
//   clear      in   1        synchronous release of all keyboard-held buttons
//   btn_out    out  NUM_BTN  registered merged button vector
//   key_hit    out  1        pulse: last key event matched at least one entry
// -----------------------------------------------------------------------------
module ps2_button_mapper #(
    parameter int          NUM_BTN      = 16,
    parameter logic [31:0] PULSE_MASK   = 32'h0,
    parameter logic [15:0] PULSE_CYCLES = 16'd1200,
    parameter int          CNT_W        = 16
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [10:0]        ps2_key,
    input  logic [NUM_BTN-1:0] joy,
    input  logic               cfg_wr,
    input  logic [4:0]         cfg_idx,
    input  logic [10:0]        cfg_entry,
    input  logic               clear,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               key_hit
);

    logic               tog_q;
    logic               key_event;
    logic [NUM_BTN-1:0] key_state;
    logic [NUM_BTN-1:0] hit;
    logic [NUM_BTN-1:0] m;
    logic [NUM_BTN-1:0] s;

    logic [NUM_BTN-1:0] tbl_valid;
    logic [NUM_BTN-1:0] tbl_wild;
    logic [8:0]         tbl_code [NUM_BTN];

    // hps_io flips bit 10 once per key event; the other bits are only
    // meaningful on that flip.
    assign key_event = ps2_key[10] ^ tog_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            hit[i] = tbl_valid[i]
                   & (tbl_code[i][7:0] == ps2_key[7:0])
                   & (tbl_wild[i] | (tbl_code[i][8] == ps2_key[8]));
        end
    end

    // Table write. The match above reads the pre-write contents, so a
    // write colliding with an event sees the old entry.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tbl_valid <= '0;
            tbl_wild  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                tbl_code[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (cfg_wr && (cfg_idx == 5'(i))) begin
                    tbl_valid[i] <= cfg_entry[10];
                    tbl_wild[i]  <= cfg_entry[9];
                    tbl_code[i]  <= cfg_entry[8:0];
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q     <= 1'b0;
            key_state <= '0;
            key_hit   <= 1'b0;
        end else begin
            tog_q   <= ps2_key[10];
            key_hit <= key_event & (|hit);
            if (clear) begin
                key_state <= '0;
            end else if (key_event) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (hit[i]) begin
                        key_state[i] <= ps2_key[9];
                    end
                end
            end
        end
    end

    assign m = key_state | joy;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        if (PULSE_MASK[g]) begin : g_stretch
            logic             m_q;
            logic [CNT_W-1:0] cnt;

            // Retrigger reloads; otherwise count down and stick at zero.
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    m_q <= 1'b0;
                    cnt <= '0;
                end else begin
                    m_q <= m[g];
                    if (m[g] && !m_q) begin
                        cnt <= CNT_W'(PULSE_CYCLES);
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            end

            assign s[g] = m[g] | (cnt != '0);
        end else begin : g_plain
            assign s[g] = m[g];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_out <= '0;
        end else begin
            btn_out <= s;
        end
    end

endmodule

// File: tb/tb_ps2_button_mapper.sv
module tb_ps2_button_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joy = '0;
    logic        cfg_wr = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [10:0] cfg_entry = '0;
    logic        clear = 1'b0;
    logic [15:0] btn_out;
    logic        key_hit;

    ps2_button_mapper #(
        .NUM_BTN     (16),
        .PULSE_MASK  (32'h0000_0080),
        .PULSE_CYCLES(16'd4),
        .CNT_W       (16)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .joy      (joy),
        .cfg_wr   (cfg_wr),
        .cfg_idx  (cfg_idx),
        .cfg_entry(cfg_entry),
        .clear    (clear),
        .btn_out  (btn_out),
        .key_hit  (key_hit)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        logic [15:0] btn;
        logic        hit;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;
    logic tog    = 1'b0;

    always @(posedge clk_sys) edge_n++;

    // Monitor: outputs after edge k are sampled on the following falling edge.
    always @(negedge clk_sys) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            e = sb.pop_front();
            if (e.cyc < edge_n) begin
                total++;
                bad++;
                $display("FAIL %s stale expectation for edge %0d (now %0d)", e.nm, e.cyc, edge_n);
            end else begin
                total++;
                if (btn_out !== e.btn) begin
                    bad++;
                    $display("FAIL %s btn_out edge %0d got=%h want=%h", e.nm, e.cyc, btn_out, e.btn);
                end
                total++;
                if (key_hit !== e.hit) begin
                    bad++;
                    $display("FAIL %s key_hit edge %0d got=%b want=%b", e.nm, e.cyc, key_hit, e.hit);
                end
            end
        end
    end

    task automatic push(input int k, input logic [15:0] b, input logic h, input string nm);
        exp_t e;
        e.cyc = k;
        e.btn = b;
        e.hit = h;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic cfg_write(input logic [4:0] idx, input logic [10:0] ent);
        cfg_wr    = 1'b1;
        cfg_idx   = idx;
        cfg_entry = ent;
        step();
        cfg_wr    = 1'b0;
    endtask

    // Key event sampled at edge K: key_hit at K, new button state at K+1.
    task automatic ev_check(input logic pressed, input logic [8:0] code,
                            input logic [15:0] b_old, input logic [15:0] b_new,
                            input logic h, input string nm);
        tog     = ~tog;
        ps2_key = {tog, pressed, code};
        push(edge_n + 1, b_old, h, nm);
        push(edge_n + 2, b_new, 1'b0, nm);
        step();
        cfg_wr = 1'b0;
        clear  = 1'b0;
        step();
        step();
    endtask

    initial begin
        int k;
        int wait_cnt;

        // Reset state
        push(1, 16'h0000, 1'b0, "reset_a");
        push(2, 16'h0000, 1'b0, "reset_b");
        step();
        step();
        reset_n = 1'b1;

        // Wildcard entry 0 matches both E0 and non-E0 codes
        cfg_write(5'd0, {1'b1, 1'b1, 9'h075});
        ev_check(1'b1, 9'h175, 16'h0000, 16'h0001, 1'b1, "wild_press");
        ev_check(1'b0, 9'h075, 16'h0001, 16'h0000, 1'b1, "wild_release");

        // Two entries sharing one code; extended variant must not match
        cfg_write(5'd3, {1'b1, 1'b0, 9'h005});
        cfg_write(5'd5, {1'b1, 1'b0, 9'h005});
        ev_check(1'b1, 9'h005, 16'h0000, 16'h0028, 1'b1, "dual_press");
        ev_check(1'b1, 9'h105, 16'h0028, 16'h0028, 1'b0, "ext_nomatch");

        // Data change without toggle is not an event
        ps2_key = {tog, 1'b1, 9'h075};
        push(edge_n + 1, 16'h0028, 1'b0, "no_toggle_a");
        push(edge_n + 2, 16'h0028, 1'b0, "no_toggle_b");
        step();
        step();
        step();

        // Write collides with event: old (invalid) entry used for match
        cfg_wr    = 1'b1;
        cfg_idx   = 5'd2;
        cfg_entry = {1'b1, 1'b0, 9'h01C};
        ev_check(1'b1, 9'h01C, 16'h0028, 16'h0028, 1'b0, "wr_collide");
        ev_check(1'b1, 9'h01C, 16'h0028, 16'h002C, 1'b1, "wr_after");

        // Out-of-range index ignored
        cfg_write(5'd20, {1'b1, 1'b1, 9'h033});
        ev_check(1'b1, 9'h033, 16'h002C, 16'h002C, 1'b0, "idx_oob");

        // Single-cycle joy[7] -> 5 cycles high
        k = edge_n + 1;
        for (int i = 0; i < 5; i++) push(k + i, 16'h00AC, 1'b0, "stretch_hi");
        push(k + 5, 16'h002C, 1'b0, "stretch_lo");
        joy = 16'h0080;
        step();
        joy = 16'h0000;
        repeat (6) step();

        // Retrigger while counter is at 2 -> reload, high through K+7
        k = edge_n + 1;
        for (int i = 0; i < 8; i++) push(k + i, 16'h00AC, 1'b0, "retrig_hi");
        push(k + 8, 16'h002C, 1'b0, "retrig_lo");
        joy = 16'h0080;
        step();
        joy = 16'h0000;
        step();
        step();
        joy = 16'h0080;
        step();
        joy = 16'h0000;
        repeat (7) step();

        // Clear overrides a simultaneous event; key_hit still pulses; joy survives
        cfg_write(5'd1, {1'b1, 1'b0, 9'h016});
        ev_check(1'b1, 9'h075, 16'h002C, 16'h002D, 1'b1, "hold0");
        ev_check(1'b1, 9'h016, 16'h002D, 16'h002F, 1'b1, "hold1");
        clear = 1'b1;
        joy   = 16'h0002;
        ev_check(1'b1, 9'h01C, 16'h002F, 16'h0002, 1'b1, "clear_ev");
        joy = 16'h0000;
        push(edge_n + 1, 16'h0000, 1'b0, "joy_drop");
        step();
        step();

        // Reset mid-stretch with a key held
        ev_check(1'b1, 9'h075, 16'h0000, 16'h0001, 1'b1, "rehold0");
        push(edge_n + 1, 16'h0081, 1'b0, "pre_rst_a");
        push(edge_n + 2, 16'h0081, 1'b0, "pre_rst_b");
        joy = 16'h0080;
        step();
        joy = 16'h0000;
        step();
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        push(edge_n, 16'h0000, 1'b0, "rst_async");
        tog     = 1'b0;
        ps2_key = '0;
        step();
        push(edge_n + 1, 16'h0000, 1'b0, "rst_hold");
        step();
        reset_n = 1'b1;
        ev_check(1'b1, 9'h075, 16'h0000, 16'h0000, 1'b0, "post_rst");

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_button_mapper.md
Name: ps2_button_mapper

Overview:
- Parametrised successor to the hard-coded PS/2 `casex` key decoder in the arcade top level.
- Turns the `hps_io` `ps2_key` event bus into a vector of `NUM_BTN` held-button bits.
- Key-to-button table is loaded at run time, not fixed in RTL.
- Joystick bits are OR-merged into the same vector; selected buttons (coin/start) get a minimum-width pulse stretch.
- Sits between `hps_io` and the core's `m_*` button wires in the `emu` top level.

Parameters:
- NUM_BTN, 16, number of mapped buttons / table entries (1..32).
- PULSE_MASK, 32'h0, bit i=1 gives button i a pulse stretch.
- PULSE_CYCLES, 16'd1200, minimum output high time in clk_sys cycles for stretched buttons (>=1).
- CNT_W, 16, width of each stretch counter; must satisfy PULSE_CYCLES < 2^CNT_W.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  `hps_io` key bus: [10] toggle, [9] pressed, [8:0] code ([8] = E0 extended).
- joy  in  NUM_BTN  joystick bits, active high, already aligned to button index.
- cfg_wr  in  1  one-cycle table write strobe.
- cfg_idx  in  5  entry index to write; values >= NUM_BTN are ignored.
- cfg_entry  in  11  [10] valid, [9] ignore-extended wildcard, [8:0] code.
- clear  in  1  synchronous release of all keyboard-held buttons.
- btn_out  out  NUM_BTN  registered merged button vector.
- key_hit  out  1  one-cycle pulse: last key event matched at least one entry.

Behaviour:
- Reset (async, reset_n=0):
  - tog_q <= 0, key_state <= 0, table entries all 0 (invalid), stretch counters 0.
  - btn_out <= 0, key_hit <= 0.
  - Deassertion is used directly; the surrounding top level synchronises it.
- Event detect:
  - An event occurs on an edge where ps2_key[10] != tog_q.
  - tog_q <= ps2_key[10] every cycle.
  - No event means key_state is unchanged, even if ps2_key[9:0] changes.
- Match, for each entry i < NUM_BTN:
  - hit_i = valid_i & (code_i[7:0] == ps2_key[7:0]) & (wild_i | code_i[8] == ps2_key[8]).
- Update on event:
  - Every i with hit_i gets key_state[i] <= ps2_key[9].
  - Multiple entries may map the same code; all update together.
  - Entries with no hit hold their value.
  - key_hit <= |hit for that one cycle, else 0.
- Table write:
  - On cfg_wr with cfg_idx < NUM_BTN: entry[cfg_idx] <= cfg_entry.
  - If cfg_wr and an event fall in the same cycle, the match uses the table contents before the write.
  - Writing an entry does not change its key_state bit.
- Clear:
  - clear=1 forces key_state <= 0 and overrides any event in the same cycle.
  - key_hit is still generated for that event.
  - tog_q still tracks ps2_key[10].
- Merge: m[i] = key_state[i] | joy[i], combinational.
- Stretch, for i with PULSE_MASK[i]=1:
  - m_q[i] is m[i] registered.
  - A rising edge of m[i] (m[i] & ~m_q[i]) loads cnt_i <= PULSE_CYCLES.
  - Otherwise, if cnt_i != 0, cnt_i decrements by 1; it saturates at 0 and never wraps.
  - A retrigger while counting reloads the counter.
  - Output term s[i] = m[i] | (cnt_i != 0).
  - Unmasked buttons: s[i] = m[i]; their counters are held at 0 and may be optimised away.
- Output: btn_out <= s every cycle.
- Latency:
  - Event applied before edge k sets key_state at edge k; btn_out reflects it after edge k+1.
  - joy input to btn_out is 1 cycle.
- Pulse width: for a stretched button whose input is a single cycle high, btn_out stays high for exactly PULSE_CYCLES+1 cycles.
- Reset mid-stretch clears the counters immediately; btn_out=0 while reset_n=0.

Test Plan:
- Load entry 0 = {1,1,9'h075}, toggle ps2_key[10] with pressed=1, code 9'h175 -> key_hit=1 for 1 cycle, btn_out[0]=1 two edges after the event. Release with code 9'h075 -> btn_out[0]=0.
- Load entries 3 and 5 both {1,0,9'h005}, press 9'h005 -> btn_out[3]=btn_out[5]=1. Press 9'h105 -> no change, key_hit=0.
- Change ps2_key[9:0] without toggling bit 10 -> btn_out unchanged, key_hit stays 0. Write entry 2 and press its code in the same cycle -> old entry value used for the match.
- PULSE_MASK=1<<7, PULSE_CYCLES=4, joy[7] high for 1 cycle -> btn_out[7] high exactly 5 cycles. Second pulse at count 2 -> reload, total high extends accordingly.
- Hold keys 0 and 1, assert clear together with a press event on key 2 -> btn_out=0 next-but-one cycle, key_hit=1. joy[1]=1 still drives btn_out[1]=1.
- Drop reset_n mid-stretch and while keys are held -> btn_out=0 and table invalid immediately. After release, a press of the previous code produces key_hit=0.
